// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Shares one DDR controller port (address FIFO, write buffer, read buffer)
// between NREQ line-granular requesters.
//   - Round-robin arbitration; the grant is held for a whole transaction.
//   - A line write is two write-buffer beats plus one address-FIFO entry.
//     Beat1 and the address push always happen in the same cycle.
//   - A line read is one address-FIFO entry. It pushes the requester ID
//     into an in-order tag FIFO.
//   - Read-return beats are routed back using the head of the tag FIFO.
// Ports:
//   i_clock / i_reset                 clock, asynchronous active-low reset
//   i_reqValid/i_reqRead/i_reqAddr/
//   i_reqWData                        per-requester request bundle
//   o_reqAck                          one-cycle pulse: transaction issued
//   o_rdDataValid/o_rdData/
//   o_rdDataLast                      read-return beat to one requester
//   i_afFull/i_wbFull/i_rbEmpty/
//   i_readData                        DDR controller status and read head
//   o_wrAF/o_afAddress/o_afRead       address FIFO push
//   o_wrWB/o_writeData                write buffer push
//   o_rdRB                            read buffer pop
//   o_rdOutstanding                   lines outstanding in the tag FIFO
module ddr_port_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDW   = 2,
    parameter int MAXRD = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NREQ-1:0]           i_reqValid,
    input  logic [NREQ-1:0]           i_reqRead,
    input  logic [NREQ*26-1:0]        i_reqAddr,
    input  logic [NREQ*256-1:0]       i_reqWData,
    output logic [NREQ-1:0]           o_reqAck,
    output logic [NREQ-1:0]           o_rdDataValid,
    output logic [127:0]              o_rdData,
    output logic                      o_rdDataLast,
    input  logic                      i_afFull,
    input  logic                      i_wbFull,
    input  logic                      i_rbEmpty,
    input  logic [127:0]              i_readData,
    output logic                      o_wrAF,
    output logic [25:0]               o_afAddress,
    output logic                      o_afRead,
    output logic                      o_wrWB,
    output logic [127:0]              o_writeData,
    output logic                      o_rdRB,
    output logic [$clog2(MAXRD):0]    o_rdOutstanding
);
    localparam int PW = $clog2(MAXRD);

    typedef enum logic {S_IDLE, S_WR1} state_t;

    state_t              r_state;
    logic [IDW-1:0]      r_rrPtr;
    logic [IDW-1:0]      r_gntId;
    logic [IDW-1:0]      r_tagMem [MAXRD];
    logic [PW-1:0]       r_tagWrPtr;
    logic [PW-1:0]       r_tagRdPtr;
    logic [PW:0]         r_tagCount;
    logic                r_beat;

    logic                w_found;
    logic [IDW-1:0]      w_winner;
    logic                w_tagFull;
    logic                w_rdIssue;
    logic                w_wr0;
    logic                w_wr1;
    logic                w_retBeat;
    logic                w_tagPop;

    // Round-robin scan starting just after the last acknowledged requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && i_reqValid[(int'(r_rrPtr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(r_rrPtr) + k) % NREQ);
            end
        end
    end

    // Every issue/return qualifier is gated by reset so that all outputs
    // read zero for as long as reset is held, regardless of the inputs.
    always_comb begin
        w_tagFull = (r_tagCount == (PW+1)'(MAXRD));
        w_rdIssue = i_reset && (r_state == S_IDLE) && w_found && i_reqRead[w_winner]
                    && !i_afFull && !w_tagFull;
        w_wr0     = i_reset && (r_state == S_IDLE) && w_found && !i_reqRead[w_winner]
                    && !i_wbFull;
        w_wr1     = i_reset && (r_state == S_WR1) && !i_wbFull && !i_afFull;
        w_retBeat = i_reset && !i_rbEmpty && (r_tagCount != '0);
        w_tagPop  = w_retBeat && r_beat;
    end

    always_comb begin
        o_wrAF        = w_rdIssue || w_wr1;
        o_afRead      = w_rdIssue;
        o_wrWB        = w_wr0 || w_wr1;
        o_afAddress   = '0;
        o_writeData   = '0;
        o_reqAck      = '0;
        if (w_rdIssue) begin
            o_afAddress        = i_reqAddr[26*int'(w_winner) +: 26];
            o_reqAck[w_winner] = 1'b1;
        end else if (w_wr1) begin
            o_afAddress        = i_reqAddr[26*int'(r_gntId) +: 26];
            o_writeData        = i_reqWData[256*int'(r_gntId) + 128 +: 128];
            o_reqAck[r_gntId]  = 1'b1;
        end else if (w_wr0) begin
            o_writeData        = i_reqWData[256*int'(w_winner) +: 128];
        end

        o_rdRB        = w_retBeat;
        o_rdData      = w_retBeat ? i_readData : '0;
        o_rdDataLast  = w_tagPop;
        o_rdDataValid = '0;
        if (w_retBeat) begin
            o_rdDataValid[r_tagMem[r_tagRdPtr]] = 1'b1;
        end
        o_rdOutstanding = i_reset ? r_tagCount : '0;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_rrPtr    <= IDW'(NREQ - 1);
            r_gntId    <= '0;
            r_tagWrPtr <= '0;
            r_tagRdPtr <= '0;
            r_tagCount <= '0;
            r_beat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr0) begin
                        r_gntId <= w_winner;
                        r_state <= S_WR1;
                    end
                end
                S_WR1: begin
                    if (w_wr1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // The pointer only moves when a transaction is acknowledged.
            if (w_rdIssue) begin
                r_rrPtr <= w_winner;
            end else if (w_wr1) begin
                r_rrPtr <= r_gntId;
            end

            if (w_rdIssue) begin
                r_tagWrPtr <= r_tagWrPtr + 1'b1;
            end
            if (w_retBeat) begin
                r_beat <= ~r_beat;
            end
            if (w_tagPop) begin
                r_tagRdPtr <= r_tagRdPtr + 1'b1;
            end
            case ({w_rdIssue, w_tagPop})
                2'b10:   r_tagCount <= r_tagCount + 1'b1;
                2'b01:   r_tagCount <= r_tagCount - 1'b1;
                default: r_tagCount <= r_tagCount;
            endcase
        end
    end

    // Tag storage has no reset; only entries between the pointers are live.
    always_ff @(posedge i_clock) begin
        if (w_rdIssue) begin
            r_tagMem[r_tagWrPtr] <= w_winner;
        end
    end
endmodule

// File: tb/tb_ddr_port_arbiter.sv
module tb_ddr_port_arbiter;
    localparam int NREQ = 2, IDW = 2, MAXRD = 8, OW = $clog2(MAXRD) + 1;

    logic i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    logic                i_reset;
    logic [NREQ-1:0]     i_reqValid, i_reqRead;
    logic [NREQ*26-1:0]  i_reqAddr;
    logic [NREQ*256-1:0] i_reqWData;
    logic [NREQ-1:0]     o_reqAck, o_rdDataValid;
    logic [127:0]        o_rdData;
    logic                o_rdDataLast;
    logic                i_afFull, i_wbFull, i_rbEmpty;
    logic [127:0]        i_readData;
    logic                o_wrAF, o_afRead, o_wrWB, o_rdRB;
    logic [25:0]         o_afAddress;
    logic [127:0]        o_writeData;
    logic [OW-1:0]       o_rdOutstanding;

    ddr_port_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAXRD(MAXRD)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_reqValid(i_reqValid), .i_reqRead(i_reqRead),
        .i_reqAddr(i_reqAddr), .i_reqWData(i_reqWData),
        .o_reqAck(o_reqAck), .o_rdDataValid(o_rdDataValid),
        .o_rdData(o_rdData), .o_rdDataLast(o_rdDataLast),
        .i_afFull(i_afFull), .i_wbFull(i_wbFull), .i_rbEmpty(i_rbEmpty),
        .i_readData(i_readData), .o_wrAF(o_wrAF), .o_afAddress(o_afAddress),
        .o_afRead(o_afRead), .o_wrWB(o_wrWB), .o_writeData(o_writeData),
        .o_rdRB(o_rdRB), .o_rdOutstanding(o_rdOutstanding)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: arbitration pointer, current write owner (-1 = none),
    // queue of requester IDs for outstanding read lines, and beat parity.
    int m_rr;
    int m_owner;
    int m_tags[$];
    bit m_beat;

    logic            e_wrAF, e_afRead, e_wrWB, e_rdRB, e_last;
    logic [25:0]     e_addr;
    logic [127:0]    e_wdata, e_rdata;
    logic [NREQ-1:0] e_ack, e_valid;
    logic [OW-1:0]   e_out;
    bit              e_rdIssue, e_wr0, e_wr1;
    int              e_win;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    function automatic void model_reset();
        m_rr = NREQ - 1;
        m_owner = -1;
        m_tags.delete();
        m_beat = 1'b0;
    endfunction

    function automatic void model_eval();
        int w;
        w = -1;
        e_rdIssue = 0; e_wr0 = 0; e_wr1 = 0;
        e_wrAF = 0; e_afRead = 0; e_wrWB = 0; e_rdRB = 0; e_last = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_ack = '0; e_valid = '0;
        if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_rr + k) % NREQ;
                if (w < 0 && i_reqValid[i]) w = i;
            end
            if (w >= 0) begin
                if (i_reqRead[w]) begin
                    if (!i_afFull && m_tags.size() < MAXRD) begin
                        e_rdIssue = 1; e_wrAF = 1; e_afRead = 1;
                        e_addr = i_reqAddr[26*w +: 26];
                        e_ack[w] = 1'b1;
                    end
                end else if (!i_wbFull) begin
                    e_wr0 = 1; e_wrWB = 1;
                    e_wdata = i_reqWData[256*w +: 128];
                end
            end
        end else if (!i_wbFull && !i_afFull) begin
            e_wr1 = 1; e_wrWB = 1; e_wrAF = 1;
            e_wdata = i_reqWData[256*m_owner + 128 +: 128];
            e_addr = i_reqAddr[26*m_owner +: 26];
            e_ack[m_owner] = 1'b1;
        end
        e_win = w;
        if (!i_rbEmpty && m_tags.size() > 0) begin
            e_rdRB = 1;
            e_rdata = i_readData;
            e_valid[m_tags[0]] = 1'b1;
            e_last = m_beat;
        end
        e_out = OW'(m_tags.size());
    endfunction

    function automatic void model_commit();
        if (e_rdRB) begin
            if (m_beat) void'(m_tags.pop_front());
            m_beat = !m_beat;
        end
        if (e_rdIssue) begin
            m_tags.push_back(e_win);
            m_rr = e_win;
        end
        if (e_wr0) m_owner = e_win;
        if (e_wr1) begin
            m_rr = m_owner;
            m_owner = -1;
        end
    endfunction

    // Inputs are driven right after a negedge; outputs are checked 1 ns later.
    task automatic eval_check();
        #1;
        model_eval();
        chk("wrAF", o_wrAF, e_wrAF);
        if (e_wrAF) chk("afRead", o_afRead, e_afRead);
        if (e_wrAF) chk("afAddress", o_afAddress, e_addr);
        chk("wrWB", o_wrWB, e_wrWB);
        if (e_wrWB) chk("writeData", o_writeData, e_wdata);
        chk("reqAck", o_reqAck, e_ack);
        chk("rdRB", o_rdRB, e_rdRB);
        chk("rdDataValid", o_rdDataValid, e_valid);
        if (e_rdRB) chk("rdData", o_rdData, e_rdata);
        chk("rdDataLast", o_rdDataLast, e_last);
        chk("rdOutstanding", o_rdOutstanding, e_out);
    endtask

    task automatic tick();
        @(posedge i_clock);
        model_commit();
        @(negedge i_clock);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"}, {o_reqAck, o_rdDataValid, o_rdData, o_rdDataLast, o_wrAF,
                          o_afAddress, o_afRead, o_wrWB, o_rdRB, o_rdOutstanding}, '0);
        chk({tag, "_b"}, o_writeData, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with active-looking inputs: every output must stay 0.
        i_reset = 1'b0;
        i_reqValid = 2'b11; i_reqRead = 2'b11;
        i_reqAddr = '1; i_reqWData = '1;
        i_afFull = 1'b0; i_wbFull = 1'b0; i_rbEmpty = 1'b0; i_readData = '1;
        repeat (2) @(negedge i_clock);
        #1;
        check_all_zero("reset_hold");
        @(negedge i_clock);
        i_reset = 1'b1;
        model_reset();
        i_reqValid = '0; i_rbEmpty = 1'b1;

        // Single read from requester 0, returned as two beats.
        i_reqValid = 2'b01; i_reqRead = 2'b01;
        i_reqAddr[25:0] = 26'h0001234;
        eval_check();
        chk("rd1_issue", {o_wrAF, o_afRead, o_afAddress, o_reqAck}, {1'b1, 1'b1, 26'h0001234, 2'b01});
        tick();
        i_reqValid = '0;
        eval_check();
        chk("rd1_outst1", o_rdOutstanding, OW'(1));
        tick();
        i_rbEmpty = 1'b0; i_readData = 128'hA;
        eval_check();
        chk("rd1_beatA", {o_rdDataValid, o_rdDataLast}, {2'b01, 1'b0});
        tick();
        i_readData = 128'hB;
        eval_check();
        chk("rd1_beatB", {o_rdDataValid, o_rdDataLast, o_rdData}, {2'b01, 1'b1, 128'hB});
        tick();
        i_rbEmpty = 1'b1;
        eval_check();
        chk("rd1_outst0", o_rdOutstanding, OW'(0));
        tick();

        // Write from requester 1, with the address FIFO full for 3 cycles in WR1.
        i_reqValid = 2'b10; i_reqRead = 2'b00;
        i_reqAddr[51:26] = 26'h2ABCDEF;
        i_reqWData[511:256] = rand256();
        eval_check();
        chk("wr_beat0", {o_wrWB, o_wrAF, o_writeData}, {1'b1, 1'b0, i_reqWData[383:256]});
        tick();
        i_afFull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            eval_check();
            chk("wr_stall", {o_wrWB, o_wrAF, o_reqAck}, '0);
            tick();
        end
        i_afFull = 1'b0;
        eval_check();
        chk("wr_beat1", {o_wrWB, o_wrAF, o_afRead, o_afAddress, o_reqAck},
            {1'b1, 1'b1, 1'b0, 26'h2ABCDEF, 2'b10});
        tick();
        i_reqValid = '0;

        // Both requesters reading back to back: grants alternate 0,1,0,1.
        i_reqValid = 2'b11; i_reqRead = 2'b11;
        i_reqAddr = {26'h0000BBB, 26'h0000AAA};
        for (int k = 0; k < 4; k++) begin
            eval_check();
            chk("alt_ack", o_reqAck, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        i_reqValid = '0; i_rbEmpty = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_readData = {$urandom, $urandom, $urandom, $urandom};
            eval_check();
            chk("ret_route", o_rdDataValid, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        i_rbEmpty = 1'b1;

        // Fill the tag FIFO; the 9th read stalls until one line returns.
        i_reqValid = 2'b01; i_reqRead = 2'b01;
        for (int k = 0; k < MAXRD; k++) begin
            eval_check();
            tick();
        end
        eval_check();
        chk("full_stall", {o_wrAF, o_rdOutstanding}, {1'b0, OW'(MAXRD)});
        tick();
        i_rbEmpty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_readData = {$urandom, $urandom, $urandom, $urandom};
            eval_check();
            chk("full_ret_stall", o_wrAF, 1'b0);
            tick();
        end
        i_rbEmpty = 1'b1;
        eval_check();
        chk("full_resume", {o_wrAF, o_reqAck}, {1'b1, 2'b01});
        tick();
        i_reqValid = '0;

        // Drain everything, then read buffer non-empty with no tags.
        i_rbEmpty = 1'b0;
        for (int k = 0; k < 2 * MAXRD; k++) begin
            i_readData = {$urandom, $urandom, $urandom, $urandom};
            eval_check();
            tick();
        end
        eval_check();
        chk("no_tag_ret", {o_rdRB, o_rdDataValid}, '0);
        tick();
        i_rbEmpty = 1'b1;

        // Asynchronous reset while a write sits in WR1.
        i_reqValid = 2'b10; i_reqRead = 2'b00;
        eval_check();
        tick();
        i_afFull = 1'b1;
        eval_check();
        i_reset = 1'b0;
        #1;
        check_all_zero("reset_wr1");
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        model_reset();
        i_afFull = 1'b0;
        i_reqValid = 2'b11; i_reqRead = 2'b11;
        eval_check();
        chk("post_reset_win", {o_reqAck, o_rdOutstanding}, {2'b01, OW'(0)});
        tick();
        i_reqValid = '0;

        // Randomized traffic; requesters hold a request until acknowledged.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!i_reqValid[i] && $urandom_range(0, 1) == 1) begin
                    i_reqValid[i] = 1'b1;
                    i_reqRead[i] = 1'($urandom_range(0, 1));
                    i_reqAddr[26*i +: 26] = 26'($urandom);
                    i_reqWData[256*i +: 256] = rand256();
                end
            end
            i_afFull = ($urandom_range(0, 3) == 0);
            i_wbFull = ($urandom_range(0, 3) == 0);
            i_rbEmpty = ($urandom_range(0, 1) == 0);
            i_readData = {$urandom, $urandom, $urandom, $urandom};
            eval_check();
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i]) i_reqValid[i] = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
